// File: rtl/jenc_pkg.sv
// Shared types and constants for the JPEG capture controller and its helpers.
package jenc_pkg;

   localparam int ENC_SIZE_W = 20;
   localparam int QF_W       = 2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_CAPTURE  = 2'd2,
      ST_ENC_WAIT = 2'd3
   } cap_state_e;

   // States in which the watchdog is allowed to run.
   function automatic logic wd_active(input cap_state_e s);
      return (s == ST_WAIT_SOF) || (s == ST_ENC_WAIT);
   endfunction

endpackage

// File: rtl/jcap_xy_counter.sv
// Pixel position counter: x wraps at x_max and bumps y; last flags the final pixel of the frame.
module jcap_xy_counter #(
   parameter int XW = 10,
   parameter int YW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          inc,
   input  logic [XW-1:0] x_max,
   input  logic [YW-1:0] y_max,
   output logic          last
);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear) begin
         x_d = '0;
         y_d = '0;
      end else if (inc) begin
         if (x_q == x_max) begin
            x_d = '0;
            y_d = y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign last = (x_q == x_max) && (y_q == y_max);

endmodule

// File: rtl/jpeg_capture_ctrl.sv
// Sequences one camera frame into the JPEG encoder: arms on a start request, gates pixels
// between frame start and the last pixel, then waits for the encoder result under a watchdog.
module jpeg_capture_ctrl
   import jenc_pkg::*;
#(
   parameter int  SENSOR_X_SIZE  = 720,
   parameter int  SENSOR_Y_SIZE  = 720,
   parameter int  TIMEOUT_CYCLES = 2**24,
   localparam int XW             = $clog2(SENSOR_X_SIZE),
   localparam int YW             = $clog2(SENSOR_Y_SIZE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_capture,
   input  logic [QF_W-1:0]       qf_select,
   input  logic [XW-1:0]         x_size_m1,
   input  logic [YW-1:0]         y_size_m1,
   input  logic                  cam_frame_valid,
   input  logic                  cam_pixel_valid,
   output logic                  enc_start,
   output logic                  enc_abort,
   output logic [QF_W-1:0]       enc_qf,
   output logic [XW-1:0]         enc_x_size_m1,
   output logic [YW-1:0]         enc_y_size_m1,
   output logic                  enc_pixel_en,
   input  logic                  enc_done,
   input  logic [ENC_SIZE_W-1:0] enc_size,
   output logic                  image_valid,
   output logic [ENC_SIZE_W-1:0] image_size,
   output logic                  busy,
   output logic                  frame_error
);

   localparam int             WDW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

   cap_state_e            state_q, state_d;
   logic                  fv_q, fv_d;
   logic [WDW-1:0]        wd_q, wd_d;
   logic [QF_W-1:0]       qf_q, qf_d;
   logic [XW-1:0]         xm_q, xm_d;
   logic [YW-1:0]         ym_q, ym_d;
   logic                  image_valid_q, image_valid_d;
   logic [ENC_SIZE_W-1:0] image_size_q, image_size_d;
   logic                  frame_error_q, frame_error_d;
   logic                  abort_q, abort_d;
   logic                  busy_q, busy_d;

   logic sof, fall, pix_fwd, wd_expired, abort_req, cnt_clear, last_pix;

   jcap_xy_counter #(.XW(XW), .YW(YW)) u_xy (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (pix_fwd),
      .x_max (xm_q),
      .y_max (ym_q),
      .last  (last_pix)
   );

   always_comb begin
      sof           = cam_frame_valid & ~fv_q;
      fall          = ~cam_frame_valid & fv_q;
      pix_fwd       = (state_q == ST_CAPTURE) & cam_pixel_valid & cam_frame_valid;
      wd_expired    = (wd_q == WD_LAST);
      state_d       = state_q;
      fv_d          = cam_frame_valid;
      qf_d          = qf_q;
      xm_d          = xm_q;
      ym_d          = ym_q;
      image_valid_d = image_valid_q;
      image_size_d  = image_size_q;
      frame_error_d = frame_error_q;
      abort_d       = 1'b0;
      abort_req     = 1'b0;
      cnt_clear     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_capture) begin
               qf_d          = qf_select;
               xm_d          = x_size_m1;
               ym_d          = y_size_m1;
               image_valid_d = 1'b0;
               frame_error_d = 1'b0;
               state_d       = ST_WAIT_SOF;
            end
         end
         ST_WAIT_SOF: begin
            if (sof) begin
               cnt_clear = 1'b1;
               state_d   = ST_CAPTURE;
            end else if (wd_expired) begin
               abort_req = 1'b1;
            end
         end
         ST_CAPTURE: begin
            // A forwarded pixel implies frame_valid is high, so it can never coincide with a fall.
            if (pix_fwd && last_pix) begin
               state_d = ST_ENC_WAIT;
            end else if (fall) begin
               abort_req = 1'b1;
            end
         end
         ST_ENC_WAIT: begin
            if (enc_done) begin
               image_size_d  = enc_size;
               image_valid_d = 1'b1;
               state_d       = ST_IDLE;
            end else if (wd_expired) begin
               abort_req = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort_req) begin
         state_d       = ST_IDLE;
         frame_error_d = 1'b1;
         abort_d       = 1'b1;
      end

      // Restarting from zero on every state change gives each waiting state a fresh budget.
      wd_d   = (state_d == state_q && wd_active(state_q)) ? wd_q + WDW'(1) : '0;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         fv_q          <= 1'b0;
         wd_q          <= '0;
         qf_q          <= '0;
         xm_q          <= '0;
         ym_q          <= '0;
         image_valid_q <= 1'b0;
         image_size_q  <= '0;
         frame_error_q <= 1'b0;
         abort_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fv_q          <= fv_d;
         wd_q          <= wd_d;
         qf_q          <= qf_d;
         xm_q          <= xm_d;
         ym_q          <= ym_d;
         image_valid_q <= image_valid_d;
         image_size_q  <= image_size_d;
         frame_error_q <= frame_error_d;
         abort_q       <= abort_d;
         busy_q        <= busy_d;
      end
   end

   // Start and pixel enable stay combinational so they line up with the sensor strobes.
   assign enc_start     = (state_q == ST_WAIT_SOF) & sof;
   assign enc_pixel_en  = pix_fwd;
   assign enc_abort     = abort_q;
   assign enc_qf        = qf_q;
   assign enc_x_size_m1 = xm_q;
   assign enc_y_size_m1 = ym_q;
   assign image_valid   = image_valid_q;
   assign image_size    = image_size_q;
   assign frame_error   = frame_error_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_jpeg_capture_ctrl.sv
// Randomized scoreboard bench for jpeg_capture_ctrl: each capture's outcome is predicted from the
// frame/timeout rules and checked by a monitor when busy drops.
module tb_jpeg_capture_ctrl;
   import jenc_pkg::*;

   localparam int XS = 720;
   localparam int YS = 720;
   localparam int XW = $clog2(XS);
   localparam int YW = $clog2(YS);
   localparam int TO = 16;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  start_capture = 1'b0;
   logic [QF_W-1:0]       qf_select = '0;
   logic [XW-1:0]         x_size_m1 = '0;
   logic [YW-1:0]         y_size_m1 = '0;
   logic                  cam_frame_valid = 1'b0;
   logic                  cam_pixel_valid = 1'b0;
   logic                  enc_done = 1'b0;
   logic [ENC_SIZE_W-1:0] enc_size = '0;
   logic                  enc_start, enc_abort, enc_pixel_en, image_valid, busy, frame_error;
   logic [QF_W-1:0]       enc_qf;
   logic [XW-1:0]         enc_x_size_m1;
   logic [YW-1:0]         enc_y_size_m1;
   logic [ENC_SIZE_W-1:0] image_size;

   jpeg_capture_ctrl #(.SENSOR_X_SIZE(XS), .SENSOR_Y_SIZE(YS), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .start_capture(start_capture), .qf_select(qf_select),
      .x_size_m1(x_size_m1), .y_size_m1(y_size_m1), .cam_frame_valid(cam_frame_valid),
      .cam_pixel_valid(cam_pixel_valid), .enc_start(enc_start), .enc_abort(enc_abort),
      .enc_qf(enc_qf), .enc_x_size_m1(enc_x_size_m1), .enc_y_size_m1(enc_y_size_m1),
      .enc_pixel_en(enc_pixel_en), .enc_done(enc_done), .enc_size(enc_size),
      .image_valid(image_valid), .image_size(image_size), .busy(busy), .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]            starts;
      logic [7:0]            aborts;
      logic [15:0]           pixels;
      logic [7:0]            lat;
      logic                  iv;
      logic                  fe;
      logic [ENC_SIZE_W-1:0] size;
      logic [QF_W-1:0]       qf;
      logic [XW-1:0]         xm;
      logic [YW-1:0]         ym;
   } res_t;

   res_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference state: what the outputs must hold between operations.
   logic [QF_W-1:0]       m_qf = '0;
   logic [XW-1:0]         m_xm = '0;
   logic [YW-1:0]         m_ym = '0;
   logic                  m_iv = 1'b0;
   logic                  m_fe = 1'b0;
   logic [ENC_SIZE_W-1:0] m_size = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_enc_start"}, 32'(enc_start), 32'd0);
      check({tag, "_enc_abort"}, 32'(enc_abort), 32'd0);
      check({tag, "_enc_pixel_en"}, 32'(enc_pixel_en), 32'd0);
      check({tag, "_image_valid"}, 32'(image_valid), 32'd0);
      check({tag, "_image_size"}, 32'(image_size), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_frame_error"}, 32'(frame_error), 32'd0);
      check({tag, "_enc_qf"}, 32'(enc_qf), 32'd0);
      check({tag, "_enc_x"}, 32'(enc_x_size_m1), 32'd0);
      check({tag, "_enc_y"}, 32'(enc_y_size_m1), 32'd0);
   endtask

   // Stray enc_done while idle must not disturb the latched results.
   task automatic idle_gap();
      enc_done = 1'b1;
      enc_size = 20'($urandom);
      tick();
      enc_done = 1'b0;
      tick();
      check("idle_image_size", 32'(image_size), 32'(m_size));
      check("idle_image_valid", 32'(image_valid), 32'(m_iv));
      check("idle_frame_error", 32'(frame_error), 32'(m_fe));
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic run_capture(input logic [QF_W-1:0] qf, input logic [XW-1:0] xm,
                              input logic [YW-1:0] ym, input int sof_delay, input bit midframe,
                              input int mid_len, input int nshort, input int done_delay,
                              input logic [ENC_SIZE_W-1:0] size, input bit collide);
      int   total, r, sent, limit;
      bit   first;
      res_t e;
      total = (int'(xm) + 1) * (int'(ym) + 1);
      r     = midframe ? mid_len + 1 + sof_delay : sof_delay;
      m_qf  = qf;
      m_xm  = xm;
      m_ym  = ym;
      m_iv  = 1'b0;
      m_fe  = 1'b0;
      e     = '0;
      if (r >= TO) begin
         e.aborts = 8'd1;
         e.lat    = 8'(TO);
         m_fe     = 1'b1;
      end else if (nshort > 0) begin
         e.starts = 8'd1;
         e.aborts = 8'd1;
         e.pixels = 16'(nshort);
         e.lat    = 8'd2;
         m_fe     = 1'b1;
      end else begin
         e.starts = 8'd1;
         e.pixels = 16'(total);
         if (done_delay >= TO) begin
            e.aborts = 8'd1;
            e.lat    = 8'(TO + 1);
            m_fe     = 1'b1;
         end else begin
            m_iv   = 1'b1;
            m_size = size;
         end
      end
      e.iv   = m_iv;
      e.fe   = m_fe;
      e.size = m_size;
      e.qf   = qf;
      e.xm   = xm;
      e.ym   = ym;
      exp_q.push_back(e);

      if (midframe) begin
         cam_frame_valid = 1'b1;
         cam_pixel_valid = 1'b1;
      end
      qf_select     = qf;
      x_size_m1     = xm;
      y_size_m1     = ym;
      start_capture = 1'b1;
      tick();
      start_capture = 1'b0;
      if (midframe) begin
         repeat (mid_len) begin
            cam_pixel_valid = 1'($urandom_range(0, 1));
            tick();
         end
         cam_frame_valid = 1'b0;
         cam_pixel_valid = 1'b0;
         tick();
      end
      if (r >= TO) begin
         cam_frame_valid = 1'b0;
         cam_pixel_valid = 1'b0;
         repeat (TO + 4) tick();
         idle_gap();
         return;
      end
      repeat (sof_delay) tick();
      cam_frame_valid = 1'b1;
      cam_pixel_valid = 1'b0;
      #2;
      check("enc_start_at_edge", 32'(enc_start), 32'd1);
      tick();
      sent  = 0;
      first = 1'b1;
      limit = (nshort > 0) ? nshort : total;
      while (sent < limit) begin
         cam_pixel_valid = ($urandom_range(0, 3) != 0);
         if (first && collide) begin
            start_capture = 1'b1;
            qf_select     = ~qf;
            x_size_m1     = xm ^ XW'(1);
            y_size_m1     = ym ^ YW'(1);
         end
         tick();
         start_capture = 1'b0;
         first         = 1'b0;
         if (cam_pixel_valid) sent++;
      end
      cam_pixel_valid = 1'b0;
      if (nshort > 0) begin
         cam_frame_valid = 1'b0;
         repeat (4) tick();
      end else begin
         repeat (done_delay) begin
            cam_pixel_valid = 1'($urandom_range(0, 1));
            tick();
         end
         cam_pixel_valid = 1'b0;
         enc_done        = 1'b1;
         enc_size        = size;
         tick();
         enc_done        = 1'b0;
         cam_frame_valid = 1'b0;
         repeat (3) tick();
      end
      idle_gap();
   endtask

   task automatic run_reset_mid();
      res_t e;
      e        = '0;
      e.starts = 8'd1;
      e.pixels = 16'd10;
      exp_q.push_back(e);
      qf_select     = 2'd3;
      x_size_m1     = XW'(7);
      y_size_m1     = YW'(3);
      start_capture = 1'b1;
      tick();
      start_capture = 1'b0;
      repeat (2) tick();
      cam_frame_valid = 1'b1;
      tick();
      cam_pixel_valid = 1'b1;
      repeat (10) tick();
      cam_pixel_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      m_qf   = '0;
      m_xm   = '0;
      m_ym   = '0;
      m_iv   = 1'b0;
      m_fe   = 1'b0;
      m_size = '0;
      check_all_zero("mid_reset");
      cam_frame_valid = 1'b0;
      repeat (3) tick();
      idle_gap();
   endtask

   // Monitor: counts what the DUT emits during each busy window and retires one expectation per window.
   initial begin : monitor
      logic busy_prev;
      int   starts, aborts, pixels, lat, since;
      res_t e;
      busy_prev = 1'b0;
      starts    = 0;
      aborts    = 0;
      pixels    = 0;
      lat       = 0;
      since     = 0;
      forever begin
         @(negedge clk);
         since++;
         if (busy === 1'b1 && busy_prev === 1'b0) begin
            starts = 0;
            aborts = 0;
            pixels = 0;
            lat    = 0;
            since  = 0;
         end
         if (enc_start === 1'b1) begin
            starts++;
            since = 0;
         end
         if (enc_pixel_en === 1'b1) begin
            pixels++;
            since = 0;
         end
         if (enc_abort === 1'b1) begin
            aborts++;
            lat = since;
         end
         if (busy === 1'b0 && busy_prev === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_completion: busy dropped with no expected result at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("enc_start_cycles", 32'(starts), 32'(e.starts));
               check("enc_abort_cycles", 32'(aborts), 32'(e.aborts));
               check("pixels_forwarded", 32'(pixels), 32'(e.pixels));
               check("abort_latency", 32'(lat), 32'(e.lat));
               check("image_valid", 32'(image_valid), 32'(e.iv));
               check("frame_error", 32'(frame_error), 32'(e.fe));
               check("image_size", 32'(image_size), 32'(e.size));
               check("enc_qf", 32'(enc_qf), 32'(e.qf));
               check("enc_x_size_m1", 32'(enc_x_size_m1), 32'(e.xm));
               check("enc_y_size_m1", 32'(enc_y_size_m1), 32'(e.ym));
            end
         end
         busy_prev = busy;
      end
   end

   initial begin : watchdog
      #500000;
      n_cmp++;
      n_err++;
      $display("FAIL sim_timeout: bench did not finish within time limit at %0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : driver
      int  total, nshort;
      bit  midframe;
      logic [XW-1:0] xm;
      logic [YW-1:0] ym;
      reset = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // qf, xm, ym, sof_delay, midframe, mid_len, nshort, done_delay, size, collide
      run_capture(2'd2, XW'(7), YW'(3), 3, 1'b0, 0, 0, 4, 20'h01234, 1'b0);
      run_capture(2'd1, XW'(3), YW'(1), 2, 1'b1, 3, 0, 2, 20'h0ABCD, 1'b0);
      run_capture(2'd3, XW'(7), YW'(3), 1, 1'b0, 0, 20, 0, 20'h00000, 1'b0);
      run_capture(2'd0, XW'(7), YW'(3), 0, 1'b0, 0, 0, 16, 20'h55555, 1'b0);
      run_capture(2'd2, XW'(5), YW'(2), 4, 1'b0, 0, 0, 3, 20'hFEDCB, 1'b1);
      run_capture(2'd1, XW'(2), YW'(2), 2, 1'b0, 0, 0, 15, 20'h13579, 1'b0);
      run_capture(2'd3, XW'(4), YW'(1), 16, 1'b0, 0, 0, 0, 20'h00001, 1'b0);
      run_capture(2'd0, XW'(0), YW'(0), 15, 1'b0, 0, 0, 1, 20'hFFFFF, 1'b0);
      run_reset_mid();

      for (int i = 0; i < 30; i++) begin
         xm       = XW'($urandom_range(0, 7));
         ym       = YW'($urandom_range(0, 3));
         total    = (int'(xm) + 1) * (int'(ym) + 1);
         nshort   = (total > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, total - 1)) : 0;
         midframe = ($urandom_range(0, 4) == 0);
         run_capture(2'($urandom), xm, ym, int'($urandom_range(0, 12)), midframe,
                     int'($urandom_range(1, 3)), nshort, int'($urandom_range(0, 17)),
                     20'($urandom), ($urandom_range(0, 3) == 0));
      end

      repeat (5) tick();
      check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
